if_fetch_unit: RTL

//  RV32I instruction-fetch stage; sits directly upstream of the decoder (ID).

---
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: req/gnt word fetch, in-order response buffering, valid/ready hand-off to ID.
// Optional opcode precheck on buffered words is compiled in when IF_ILLEGAL_PRECHECK_EN is defined.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        id_valid_o,
   output logic [31:0] id_instr_o,
   output logic [31:0] id_pc_o,
   input  logic        id_ready_i,
   output logic        id_illegal_o
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      fetch_pc_q;
   logic [CNT_W-1:0] outstanding_q, discard_q, discard_d, fifo_count_q, rsp_left;
   logic [PTR_W-1:0] fifo_wr_q, fifo_rd_q, pend_wr_q, pend_rd_q;
   logic [31:0]      fifo_instr_q [FIFO_DEPTH];
   logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
   logic [31:0]      pend_pc_q    [FIFO_DEPTH];
   logic             flush, handshake, push, pop, fifo_full;
   logic [SUM_W-1:0] credits_used;

   assign flush        = redirect_i && (state_q != S_IDLE);
   assign handshake    = imem_req_o && imem_gnt_i;
   assign push         = (state_q == S_RUN) && imem_rvalid_i && !redirect_i;
   assign pop          = id_valid_o && id_ready_i && !flush;
   assign fifo_full    = (fifo_count_q == CNT_W'(FIFO_DEPTH));
   assign rsp_left     = outstanding_q - CNT_W'(imem_rvalid_i);
   assign credits_used = SUM_W'(outstanding_q) + SUM_W'(fifo_count_q);

   // Responses still to be dropped: reloaded on redirect, counted down in FLUSH
   always_comb begin
      discard_d = discard_q;
      if (flush) begin
         discard_d = rsp_left;
      end else if ((state_q == S_FLUSH) && imem_rvalid_i) begin
         discard_d = discard_q - CNT_W'(1);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_RUN;
         S_RUN:   if (flush && (discard_d != '0)) state_d = S_FLUSH;
         S_FLUSH: if (discard_d == '0) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic; a request is only raised while a free buffer slot is guaranteed
   always_comb begin
      imem_req_o  = 1'b0;
      id_valid_o  = 1'b0;
      imem_addr_o = fetch_pc_q;
      id_instr_o  = fifo_instr_q[fifo_rd_q];
      id_pc_o     = fifo_pc_q[fifo_rd_q];
      if ((state_q == S_RUN) && !redirect_i && (credits_used < SUM_W'(FIFO_DEPTH))) begin
         imem_req_o = 1'b1;
      end
      if (fifo_count_q != '0) begin
         id_valid_o = 1'b1;
      end
   end

   // Fetch PC, credit counters and queue pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         fifo_count_q  <= '0;
         fifo_wr_q     <= '0;
         fifo_rd_q     <= '0;
         pend_wr_q     <= '0;
         pend_rd_q     <= '0;
      end else begin
         outstanding_q <= outstanding_q + CNT_W'(handshake) - CNT_W'(imem_rvalid_i);
         discard_q     <= discard_d;
         if (flush) begin
            fetch_pc_q   <= redirect_pc_i & 32'hFFFF_FFFC;
            fifo_count_q <= '0;
            fifo_wr_q    <= '0;
            fifo_rd_q    <= '0;
            pend_wr_q    <= '0;
            pend_rd_q    <= '0;
         end else begin
            if (handshake) begin
               fetch_pc_q <= fetch_pc_q + 32'd4;
               pend_wr_q  <= pend_wr_q + PTR_W'(1);
            end
            if (push) begin
               fifo_wr_q <= fifo_wr_q + PTR_W'(1);
               pend_rd_q <= pend_rd_q + PTR_W'(1);
            end
            if (pop) begin
               fifo_rd_q <= fifo_rd_q + PTR_W'(1);
            end
            fifo_count_q <= fifo_count_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // Payload storage; the PC of each returning word comes from the pending-PC queue head
   always_ff @(posedge clk) begin
      if (handshake) begin
         pend_pc_q[pend_wr_q] <= fetch_pc_q;
      end
      if (push) begin
         fifo_instr_q[fifo_wr_q] <= imem_rdata_i;
         fifo_pc_q[fifo_wr_q]    <= pend_pc_q[pend_rd_q];
      end
   end

`ifdef IF_ILLEGAL_PRECHECK_EN
   logic fifo_ill_q [FIFO_DEPTH];

   function automatic logic instr_illegal(input logic [31:0] w);
      case (w[6:0])
         7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
         7'h37, 7'h17, 7'h6F, 7'h0F, 7'h73: instr_illegal = 1'b0;
         default:                          instr_illegal = 1'b1;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_ill_q[fifo_wr_q] <= instr_illegal(imem_rdata_i);
      end
   end

   assign id_illegal_o = id_valid_o && fifo_ill_q[fifo_rd_q];
`else
   assign id_illegal_o = 1'b0;
`endif

   // Credits must make a push into a full buffer impossible
   assert property (@(posedge clk) disable iff (rst) !(push && !pop && fifo_full));

endmodule
